// File: rtl/pha_meas.sv
// rtl/pha_meas.sv - phase lag of a dut square wave behind a ref square wave, as a 12-bit word and in degrees
module pha_meas #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_ref_in,
  input  logic        sig_dut_in,
  output logic [11:0] pha_word_out,
  output logic [11:0] pha_oled_out,
  output logic        valid_out,
  output logic        nosig_out
);

  typedef enum logic [1:0] {IDLE, MEAS, DIV, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(15);

  state_t           state, state_nxt;
  logic [2:0]       ref_sync, dut_sync;
  logic             ref_edge, dut_edge;
  logic [CNT_W-1:0] period_cnt, delay_cnt;
  logic             dut_seen;
  logic             close_ok, start_div, discard, timeout_hit;
  logic [CNT_W:0]   div_p, div_rem, rem_sub;
  logic [CNT_W+1:0] rem_sh;
  logic [11:0]      div_q, w_next;
  logic [3:0]       div_cnt;
  logic             q_bit, div_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sync <= '0;
      dut_sync <= '0;
    end else begin
      ref_sync <= {ref_sync[1:0], sig_ref_in};
      dut_sync <= {dut_sync[1:0], sig_dut_in};
    end
  end

  assign ref_edge = ref_sync[1] & ~ref_sync[2];
  assign dut_edge = dut_sync[1] & ~dut_sync[2];

  // Counting runs through DIV/DONE too; any ref edge restarts the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      delay_cnt  <= '0;
      dut_seen   <= 1'b0;
    end else if (ref_edge) begin
      period_cnt <= '0;
      delay_cnt  <= '0;
      dut_seen   <= dut_edge;
    end else if (state != IDLE) begin
      if (period_cnt != CNT_MAX) period_cnt <= period_cnt + 1'b1;
      if (!dut_seen) begin
        if (delay_cnt != CNT_MAX) delay_cnt <= delay_cnt + 1'b1;
        if (dut_edge) dut_seen <= 1'b1;
      end
    end
  end

  assign close_ok    = dut_seen && (period_cnt >= MIN_CNT);
  assign start_div   = (state == MEAS) && ref_edge && close_ok;
  assign discard     = (state == MEAS) && ref_edge && !close_ok;
  assign timeout_hit = (state == MEAS) && !ref_edge && (period_cnt >= TO_CNT);

  // Restoring division of D*4096 by P: shift remainder, try-subtract, one quotient bit per cycle.
  assign rem_sh   = {div_rem, 1'b0};
  assign q_bit    = rem_sh >= {1'b0, div_p};
  assign rem_sub  = (CNT_W+1)'(rem_sh - {1'b0, div_p});
  assign w_next   = {div_q[10:0], q_bit};
  assign div_last = (div_cnt == 4'd11);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_p        <= '0;
      div_rem      <= '0;
      div_q        <= '0;
      div_cnt      <= '0;
      pha_word_out <= '0;
      pha_oled_out <= '0;
      nosig_out    <= 1'b1;
    end else begin
      if (start_div) begin
        div_p   <= (CNT_W+1)'(period_cnt) + 1'b1;
        div_rem <= {1'b0, delay_cnt};
        div_q   <= '0;
        div_cnt <= '0;
      end else if (state == DIV) begin
        div_rem <= q_bit ? rem_sub : rem_sh[CNT_W:0];
        div_q   <= w_next;
        div_cnt <= div_cnt + 1'b1;
        if (div_last) begin
          pha_word_out <= w_next;
          pha_oled_out <= 12'((21'(w_next) * 21'd360) >> 12);
          nosig_out    <= 1'b0;
        end
      end
      if (discard || timeout_hit) nosig_out <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ref_edge) state_nxt = MEAS;
      MEAS: begin
        if (start_div)        state_nxt = DIV;
        else if (timeout_hit) state_nxt = IDLE;
      end
      DIV:  if (div_last) state_nxt = DONE;
      DONE: state_nxt = MEAS;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_out = (state == DONE);
  end

endmodule

// File: tb/tb_pha_meas.sv
// tb/tb_pha_meas.sv - directed self-checking bench for pha_meas
module tb_pha_meas;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_ref_in = 1'b0;
  logic        sig_dut_in = 1'b0;
  logic [11:0] pha_word_out;
  logic [11:0] pha_oled_out;
  logic        valid_out;
  logic        nosig_out;

  int cyc = 0;
  int valid_total = 0;
  int last_valid_cyc = -1;
  int last_rise = 0;
  int tests = 0;
  int fails = 0;
  int v0;

  pha_meas #(.CNT_W(24), .TIMEOUT(5000)) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_ref_in   (sig_ref_in),
    .sig_dut_in   (sig_dut_in),
    .pha_word_out (pha_word_out),
    .pha_oled_out (pha_oled_out),
    .valid_out    (valid_out),
    .nosig_out    (nosig_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) begin
      valid_total    = valid_total + 1;
      last_valid_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ref pulses high for 4 cycles at the start of each period; dut pulses 4 cycles at lag (and lag2 if >= 0)
  task automatic run(input int period, input int lag, input int lag2, input bit dut_on,
                     input int nper, input int rst_at);
    int c;
    for (int i = 0; i < period * nper; i++) begin
      c = i % period;
      @(negedge clk);
      if (c == 0) last_rise = cyc;
      sig_ref_in = (c < 4);
      sig_dut_in = dut_on && ((((c - lag + period) % period) < 4) ||
                              (lag2 >= 0 && (((c - lag2 + period) % period) < 4)));
      rst = (i == rst_at);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_word", pha_word_out, 0);
    check("reset_oled", pha_oled_out, 0);
    check("reset_valid", valid_out, 0);
    check("reset_nosig", nosig_out, 1);
    rst = 1'b0;

    v0 = valid_total;
    run(1000, 250, -1, 1'b1, 3, -1);
    check("lag250_word", pha_word_out, 1024);
    check("lag250_oled", pha_oled_out, 90);
    check("lag250_nosig", nosig_out, 0);
    check("lag250_valid_count", valid_total - v0, 2);
    check("lag250_latency", last_valid_cyc, last_rise + 15);

    v0 = valid_total;
    run(1000, 0, -1, 1'b1, 3, -1);
    check("lag0_word", pha_word_out, 0);
    check("lag0_oled", pha_oled_out, 0);
    check("lag0_valid_count", valid_total - v0, 3);

    v0 = valid_total;
    run(1000, 999, -1, 1'b1, 3, -1);
    check("lag999_word", pha_word_out, 4091);
    check("lag999_oled", pha_oled_out, 359);
    check("lag999_valid_count", valid_total - v0, 3);

    v0 = valid_total;
    run(1000, 0, -1, 1'b0, 3, -1);
    check("dutlow_valid_count", valid_total - v0, 1);
    check("dutlow_nosig", nosig_out, 1);
    check("dutlow_word_hold", pha_word_out, 4091);
    check("dutlow_oled_hold", pha_oled_out, 359);

    v0 = valid_total;
    run(12, 3, -1, 1'b1, 5, -1);
    check("short_valid_count", valid_total - v0, 0);
    check("short_nosig", nosig_out, 1);
    check("short_word_hold", pha_word_out, 4091);

    v0 = valid_total;
    run(1000, 100, 500, 1'b1, 3, -1);
    check("twodut_word", pha_word_out, 409);
    check("twodut_oled", pha_oled_out, 35);
    check("twodut_nosig", nosig_out, 0);
    check("twodut_valid_count", valid_total - v0, 2);

    v0 = valid_total;
    sig_ref_in = 1'b0;
    sig_dut_in = 1'b0;
    while (cyc < last_rise + 4995) @(negedge clk);
    check("timeout_before", nosig_out, 0);
    while (cyc < last_rise + 5010) @(negedge clk);
    check("timeout_after", nosig_out, 1);
    check("timeout_word_hold", pha_word_out, 409);
    check("timeout_oled_hold", pha_oled_out, 35);
    check("timeout_valid_count", valid_total - v0, 0);

    v0 = valid_total;
    run(1000, 250, -1, 1'b1, 2, 1006);
    check("rstdiv_valid_count", valid_total - v0, 0);
    check("rstdiv_word", pha_word_out, 0);
    check("rstdiv_oled", pha_oled_out, 0);
    check("rstdiv_nosig", nosig_out, 1);

    v0 = valid_total;
    run(1000, 250, -1, 1'b1, 2, -1);
    check("recover_valid_count", valid_total - v0, 1);
    check("recover_word", pha_word_out, 1024);
    check("recover_oled", pha_oled_out, 90);
    check("recover_nosig", nosig_out, 0);
    check("recover_latency", last_valid_cyc, last_rise + 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pha_meas.md
PHA_MEAS -- requirements
Module: pha_meas

Interface
REQ-001 The block SHALL have parameter CNT_W, default 24: width of the period and delay counters.
REQ-002 The block SHALL have parameter TIMEOUT, default 5000000: cycles without a ref rising edge before no-signal is declared.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port sig_ref_in, input, 1 bit: reference square wave, asynchronous to clk.
REQ-006 The block SHALL have port sig_dut_in, input, 1 bit: measured square wave, asynchronous to clk.
REQ-007 The block SHALL have port pha_word_out, output, 12 bits: phase lag of dut behind ref; 4096 = 360 deg.
REQ-008 The block SHALL have port pha_oled_out, output, 12 bits: {3'b000, deg[8:0]} with deg in 0..359.
REQ-009 The block SHALL have port valid_out, output, 1 bit: one-cycle pulse when both phase outputs update.
REQ-010 The block SHALL have port nosig_out, output, 1 bit: level, high while no valid measurement is possible.

Function
REQ-011 Each input SHALL pass a 2-flop synchronizer; a rising edge SHALL be flagged on the cycle the 2nd flop reads 1 and a 3rd history flop reads 0.
REQ-012 Measurement FSM states SHALL be IDLE, MEAS, DIV, DONE.
REQ-013 IDLE: on ref edge, clear period_cnt and delay_cnt to 0, clear dut_seen, and go to MEAS.
REQ-014 MEAS: period_cnt SHALL increment by 1 every cycle without a ref edge.
REQ-015 MEAS: while dut_seen=0, delay_cnt SHALL increment every cycle; the first dut edge SHALL set dut_seen and freeze delay_cnt; later dut edges in the same period SHALL be ignored.
REQ-016 MEAS: a ref edge SHALL close the period: latch P=period_cnt+1 and D=delay_cnt, then restart counting exactly as in REQ-013.
REQ-017 MEAS: in the same closing cycle, go to DIV if dut_seen=1 and P>=16; otherwise discard, set nosig_out=1, and remain in MEAS.
REQ-018 A dut edge in the same cycle as the opening ref edge SHALL give D=0.
REQ-019 DIV: W=floor(D*4096/P) SHALL be computed by restoring division, one quotient bit per cycle, 12 cycles, MSB first; D<P guarantees W<=4095.
REQ-020 Counting of the next period SHALL continue during DIV.
REQ-021 A ref edge arriving during DIV or DONE SHALL NOT be lost: the closing-edge handling SHALL use the running counters, and that period SHALL be discarded if the divider is busy.
REQ-022 DONE (one cycle): pha_word_out<=W; deg=(W*360)>>12 truncated; pha_oled_out<={3'b000,deg[8:0]}; valid_out=1 for this cycle only; nosig_out<=0; return to MEAS.
REQ-023 Latency: if the closing ref edge is flagged in cycle T, outputs and the valid pulse SHALL appear in cycle T+13.
REQ-024 Timeout: if period_cnt reaches TIMEOUT in MEAS, set nosig_out=1 and go to IDLE.
REQ-025 On timeout, pha_word_out and pha_oled_out SHALL hold their last values.
REQ-026 Counters SHALL saturate, never wrap, and SHALL NOT exceed 2^CNT_W-1; TIMEOUT SHALL be < 2^CNT_W.

Reset
REQ-027 While rst=1, the FSM SHALL go to IDLE, all counters and the synchronizer/history flops SHALL clear to 0, pha_word_out=0, pha_oled_out=0, valid_out=0, and nosig_out=1.
REQ-028 Reset asserted mid-MEAS or mid-DIV SHALL abort the measurement, and no valid_out SHALL follow.
REQ-029 After rst deasserts, the first result SHALL require one full ref period plus 13 cycles.

Verification
REQ-030 Ref period 1000 cycles with dut lagging by 250 -> pha_word_out=1024, pha_oled_out=90, valid_out pulse once per period, nosig_out=0.
REQ-031 Dut identical to ref (lag 0) -> pha_word_out=0, pha_oled_out=0; lag 999 of 1000 -> pha_word_out=4091, pha_oled_out=359.
REQ-032 Dut held low, ref period 1000 -> no valid_out, nosig_out=1, outputs hold their previous values.
REQ-033 With TIMEOUT=5000, stop ref after a valid result -> nosig_out rises 5000 cycles after the last ref edge count restart, and outputs are held.
REQ-034 rst pulsed during DIV -> no valid_out, outputs 0, nosig_out=1; the next full period then yields a correct result at T+13.
REQ-035 Ref period 12 cycles -> no valid_out, nosig_out=1; two dut edges in one period -> only the first is used.
